bridge_decoder: RTL

- Shares one host bridge port (APF bridge, 32-bit address/data) among N_DEV endpoint bridge ports, e.g. an ID block, control registers and a memory window.
- Decodes the address into a device window, forwards write and read strobes to exactly one endpoint, and returns that endpoint's read data with a fixed, pipelined latency.
- Unmapped accesses are absorbed; reads of unmapped addresses return MISS_DATA and are counted.
- Sits directly behind the top-level bridge; endpoints never see the raw host port.

---
 rtl/bridge_pkg.sv | 22 ++
 rtl/bridge_rd_pipe.sv | 43 ++++
 rtl/bridge_decoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared widths, window descriptor and address-decode helper
// for the host-to-endpoint bridge decoder.
package bridge_pkg;

  localparam int BRIDGE_AW = 32;
  localparam int BRIDGE_DW = 32;

  localparam logic [BRIDGE_DW-1:0] BRIDGE_MISS_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [BRIDGE_AW-1:0] base;
    logic [BRIDGE_AW-1:0] mask;
  } bridge_window_t;

  function automatic logic window_hit(
    input logic [BRIDGE_AW-1:0] addr,
    input bridge_window_t       win
  );
    return (addr & win.mask) == win.base;
  endfunction

endpackage

// File: rtl/bridge_rd_pipe.sv
// Fixed-depth delay line carrying {valid, hit, sel} of each
// decoded read toward the return-data mux.
module bridge_rd_pipe #(
  parameter int SEL_W = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_i,
  input  logic             hit_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             vld_o,
  output logic             hit_o,
  output logic [SEL_W-1:0] sel_o
);

  localparam int E_W = SEL_W + 2;

  logic [E_W-1:0]            push_d;
  logic [DEPTH-1:0][E_W-1:0] line_q;

  assign push_d = {vld_i, hit_i, sel_i};
  assign {vld_o, hit_o, sel_o} = line_q[DEPTH-1];

  if (DEPTH > 1) begin : g_shift
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        line_q <= '0;
      end else begin
        line_q <= {line_q[DEPTH-2:0], push_d};
      end
    end
  end else begin : g_single
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        line_q <= '0;
      end else begin
        line_q <= push_d;
      end
    end
  end

endmodule

// File: rtl/bridge_decoder.sv
// Shares one host bridge port among N_DEV endpoints: one decode
// stage, broadcast addr/data, pipelined read return, miss counter.
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int N_DEV = 4,
  parameter logic [N_DEV-1:0][BRIDGE_AW-1:0] BASE = {
    32'h8300_0000, 32'h8200_0000, 32'h8100_0000, 32'h8000_0000
  },
  parameter logic [N_DEV-1:0][BRIDGE_AW-1:0] MASK = {N_DEV{32'hFF00_0000}},
  parameter int RD_LATENCY = 1,
  parameter logic [BRIDGE_DW-1:0] MISS_DATA = BRIDGE_MISS_DATA
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [BRIDGE_AW-1:0]            host_addr,
  input  logic                            host_wr,
  input  logic [BRIDGE_DW-1:0]            host_wr_data,
  input  logic                            host_rd,
  output logic [BRIDGE_DW-1:0]            host_rd_data,
  output logic [N_DEV-1:0][BRIDGE_AW-1:0] dev_addr,
  output logic [N_DEV-1:0]                dev_wr,
  output logic [N_DEV-1:0][BRIDGE_DW-1:0] dev_wr_data,
  output logic [N_DEV-1:0]                dev_rd,
  input  logic [N_DEV-1:0][BRIDGE_DW-1:0] dev_rd_data,
  output logic                            miss_pulse,
  output logic [15:0]                     miss_count
);

  localparam int SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  logic                 hit_d, hit_q;
  logic [SEL_W-1:0]     sel_d, sel_q;
  logic                 miss_d, miss_q;
  logic [15:0]          cnt_d, cnt_q;
  logic [BRIDGE_AW-1:0] addr_q;
  logic [BRIDGE_DW-1:0] wr_data_q;
  logic                 wr_q, rd_q;
  logic [BRIDGE_DW-1:0] rd_data_d, rd_data_q;
  logic                 pipe_vld, pipe_hit;
  logic [SEL_W-1:0]     pipe_sel;

  // Descending scan so the lowest matching index wins on overlap.
  always_comb begin
    hit_d = 1'b0;
    sel_d = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (window_hit(host_addr,
                     bridge_window_t'{base: BASE[i], mask: MASK[i]})) begin
        hit_d = 1'b1;
        sel_d = SEL_W'(i);
      end
    end
  end

  assign miss_d = (host_wr | host_rd) & ~hit_d;
  assign cnt_d  = (miss_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      hit_q     <= 1'b0;
      sel_q     <= '0;
      miss_q    <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      addr_q    <= host_addr;
      wr_data_q <= host_wr_data;
      wr_q      <= host_wr;
      rd_q      <= host_rd;
      hit_q     <= hit_d;
      sel_q     <= sel_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    dev_addr    = '0;
    dev_wr_data = '0;
    dev_wr      = '0;
    dev_rd      = '0;
    for (int i = 0; i < N_DEV; i++) begin
      dev_addr[i]    = addr_q;
      dev_wr_data[i] = wr_data_q;
      dev_wr[i]      = wr_q & hit_q & (sel_q == SEL_W'(i));
      dev_rd[i]      = rd_q & hit_q & (sel_q == SEL_W'(i));
    end
  end

  bridge_rd_pipe #(
    .SEL_W (SEL_W),
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .vld_i (rd_q),
    .hit_i (hit_q),
    .sel_i (sel_q),
    .vld_o (pipe_vld),
    .hit_o (pipe_hit),
    .sel_o (pipe_sel)
  );

  // Return data holds between reads; only a completing read updates it.
  always_comb begin
    rd_data_d = rd_data_q;
    if (pipe_vld) begin
      rd_data_d = pipe_hit ? dev_rd_data[pipe_sel] : MISS_DATA;
    end
  end

  assign host_rd_data = rd_data_q;
  assign miss_pulse   = miss_q;
  assign miss_count   = cnt_q;

endmodule
